mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (IFU fetch, LSU load/store) arbiter in front of a
// single memory port, with at most one transaction outstanding.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ifu_req_*  / ifu_resp_*       fetch request (read-only) and response
//   lsu_req_*  / lsu_resp_*       load/store request and response
//   mem_req_valid/ready, mem_addr, mem_wen, mem_wdata, mem_wmask
//                                 shared memory request channel
//   mem_resp_valid, mem_rdata     shared memory response channel
//
// Configuration
//   MEM_ARBITER_ROUND_ROBIN_EN    defined: ties alternate against last_grant
//                                 undefined: fixed priority, LSU wins ties
//
// Responses are delivered in the same cycle mem_resp_valid arrives, and a
// wait counter forces an error response after TIMEOUT_CYC silent WAIT cycles.

module mem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_resp_rdata,
    output logic                ifu_resp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_resp_rdata,
    output logic                lsu_resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 8;
    // The wait counter is 8 bits wide; TIMEOUT_CYC is taken modulo 256.
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } mem_req_t;

    state_t           state;
    state_t           state_nxt;
    owner_t           owner;
    owner_t           last_grant;
    logic [CNT_W-1:0] wait_cnt;
    mem_req_t         req_q;
    mem_req_t         req_d;

    logic tie_lsu;
    logic grant_lsu;
    logic accept;
    logic resp_fire;

    // Tie-break: round-robin flips against the last owner, fixed favours LSU.
    assign tie_lsu   = RR_EN ? (last_grant == OWN_IFU) : 1'b1;
    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || tie_lsu);
    assign accept    = (state == ST_IDLE) && (ifu_req_valid || lsu_req_valid);
    // A real response beats a timeout landing in the same cycle.
    assign resp_fire = (state == ST_WAIT) && (mem_resp_valid || (wait_cnt == TIMEOUT_VAL));

    // Request payload captured on a handshake; fetches never write.
    always_comb begin
        req_d      = '0;
        req_d.addr = ifu_req_addr;
        if (grant_lsu) begin
            req_d.addr  = lsu_req_addr;
            req_d.wen   = lsu_req_wen;
            req_d.wdata = lsu_req_wdata;
            req_d.wmask = lsu_req_wmask;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)        state_nxt = ST_ISSUE;
            ST_ISSUE: if (mem_req_ready) state_nxt = ST_WAIT;
            ST_WAIT:  if (resp_fire)     state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    // Latched request, owner, grant history and WAIT cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= '0;
            owner      <= OWN_IFU;
            last_grant <= OWN_IFU;
            wait_cnt   <= '0;
        end else begin
            if (accept) begin
                req_q      <= req_d;
                owner      <= grant_lsu ? OWN_LSU : OWN_IFU;
                last_grant <= grant_lsu ? OWN_LSU : OWN_IFU;
            end
            if ((state == ST_ISSUE) && mem_req_ready) begin
                wait_cnt <= '0;
            end else if ((state == ST_WAIT) && !mem_resp_valid && (wait_cnt != TIMEOUT_VAL)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_addr  = req_q.addr;
    assign mem_wen   = req_q.wen;
    assign mem_wdata = req_q.wdata;
    assign mem_wmask = req_q.wmask;

    // Handshake and response outputs; everything is held low while rst is high.
    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_resp_rdata = '0;
        ifu_resp_err   = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_resp_rdata = '0;
        lsu_resp_err   = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    ifu_req_ready = ifu_req_valid && !grant_lsu;
                    lsu_req_ready = grant_lsu;
                end
                ST_ISSUE: begin
                    mem_req_valid = 1'b1;
                end
                ST_WAIT: begin
                    if (resp_fire) begin
                        if (owner == OWN_LSU) begin
                            lsu_resp_valid = 1'b1;
                            lsu_resp_rdata = mem_resp_valid ? mem_rdata : '0;
                            lsu_resp_err   = !mem_resp_valid;
                        end else begin
                            ifu_resp_valid = 1'b1;
                            ifu_resp_rdata = mem_resp_valid ? mem_rdata : '0;
                            ifu_resp_err   = !mem_resp_valid;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// transactions, each checked cycle by cycle against a transaction-level model.

`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TO     = 12;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_resp_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
    logic [31:0] lsu_req_addr, lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic m_last;       // model's last grant: 0 = IFU, 1 = LSU

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Arbitration rule: a lone requester wins; ties follow the configured policy.
    function automatic logic pick_lsu(input logic iv, input logic lv);
        if (!lv) return 1'b0;
        if (!iv) return 1'b1;
        return RR_EN ? !m_last : 1'b1;
    endfunction

    // Idle cycles with stray memory responses that must be ignored.
    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            ifu_req_valid  = 1'b0;
            lsu_req_valid  = 1'b0;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'($urandom);
            mem_rdata      = $urandom;
            #1;
            check("idle_ifu_resp_valid", 64'(ifu_resp_valid), 64'(0));
            check("idle_lsu_resp_valid", 64'(lsu_resp_valid), 64'(0));
            check("idle_resp_rdata", 64'(ifu_resp_rdata | lsu_resp_rdata), 64'(0));
            check("idle_mem_req_valid", 64'(mem_req_valid), 64'(0));
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
    endtask

    // One full transaction: handshake, ISSUE held rdy_dly cycles, then either a
    // response after resp_dly WAIT cycles or a timeout after TO cycles.
    task automatic run_txn(input logic iv, input logic lv,
                           input logic [31:0] ia, input logic [31:0] la, input logic lw,
                           input logic [31:0] ld, input logic [3:0] lm,
                           input int rdy_dly, input bit respond, input int resp_dly,
                           input logic [31:0] rd, output logic won_lsu);
        logic        exp_lsu, ew, fire;
        logic        own_v, oth_v, own_e;
        logic [31:0] ea, ed, own_d, oth_d;
        logic [3:0]  em;
        int          n;
        exp_lsu = pick_lsu(iv, lv);
        ea = exp_lsu ? la : ia;
        ew = exp_lsu ? lw : 1'b0;
        ed = exp_lsu ? ld : 32'h0;
        em = exp_lsu ? lm : 4'h0;

        @(negedge clk);
        ifu_req_valid  = iv;
        ifu_req_addr   = ia;
        lsu_req_valid  = lv;
        lsu_req_addr   = la;
        lsu_req_wen    = lw;
        lsu_req_wdata  = ld;
        lsu_req_wmask  = lm;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        won_lsu = lsu_req_ready;
        check("ifu_req_ready", 64'(ifu_req_ready), 64'(iv && !exp_lsu));
        check("lsu_req_ready", 64'(lsu_req_ready), 64'(exp_lsu));
        check("mem_req_valid_idle", 64'(mem_req_valid), 64'(0));
        m_last = exp_lsu;

        for (int i = 0; i <= rdy_dly; i++) begin
            @(negedge clk);
            ifu_req_valid = 1'($urandom);
            lsu_req_valid = 1'($urandom);
            ifu_req_addr  = $urandom;
            lsu_req_addr  = $urandom;
            lsu_req_wen   = 1'($urandom);
            lsu_req_wdata = $urandom;
            lsu_req_wmask = 4'($urandom);
            mem_req_ready = (i == rdy_dly);
            #1;
            check("mem_req_valid", 64'(mem_req_valid), 64'(1));
            check("mem_addr", 64'(mem_addr), 64'(ea));
            check("mem_wen", 64'(mem_wen), 64'(ew));
            check("mem_wdata", 64'(mem_wdata), 64'(ed));
            check("mem_wmask", 64'(mem_wmask), 64'(em));
            check("issue_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
        end

        n = respond ? resp_dly : int'(TO);
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            ifu_req_valid  = 1'($urandom);
            lsu_req_valid  = 1'($urandom);
            mem_resp_valid = respond && (k == n);
            mem_rdata      = mem_resp_valid ? rd : $urandom;
            #1;
            fire  = (k == n);
            own_v = exp_lsu ? lsu_resp_valid : ifu_resp_valid;
            oth_v = exp_lsu ? ifu_resp_valid : lsu_resp_valid;
            own_d = exp_lsu ? lsu_resp_rdata : ifu_resp_rdata;
            oth_d = exp_lsu ? ifu_resp_rdata : lsu_resp_rdata;
            own_e = exp_lsu ? lsu_resp_err : ifu_resp_err;
            check("own_resp_valid", 64'(own_v), 64'(fire));
            check("other_resp_valid", 64'(oth_v), 64'(0));
            check("other_resp_rdata", 64'(oth_d), 64'(0));
            check("wait_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
            check("wait_mem_req_valid", 64'(mem_req_valid), 64'(0));
            check("own_resp_rdata", 64'(own_d), 64'((fire && respond) ? rd : 32'h0));
            check("own_resp_err", 64'(own_e), 64'(fire && !respond));
        end
    endtask

    logic [3:0] tie_exp;
    logic       won;
    int         r;

    initial begin
        rst            = 1'b1;
        ifu_req_valid  = 1'b0;
        ifu_req_addr   = '0;
        lsu_req_valid  = 1'b0;
        lsu_req_addr   = '0;
        lsu_req_wen    = 1'b0;
        lsu_req_wdata  = '0;
        lsu_req_wmask  = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        m_last         = 1'b0;

        // Reset: requests present, everything must stay quiet.
        repeat (2) @(negedge clk);
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        check("rst_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        check("rst_resp_valid", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
        check("rst_resp_err", 64'({ifu_resp_err, lsu_resp_err}), 64'(0));
        check("rst_resp_rdata", 64'(ifu_resp_rdata | lsu_resp_rdata), 64'(0));
        check("rst_mem_fields", 64'(mem_addr | mem_wdata), 64'(0));
        check("rst_mem_wen_wmask", 64'({mem_wen, mem_wmask}), 64'(0));
        @(negedge clk);
        rst           = 1'b0;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        #1;
        check("post_rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        idle_cycles(1);

        // Single zero-wait IFU read.
        run_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0,
                0, 1'b1, 0, 32'h0000_0413, won);
        check("single_ifu_grant", 64'(won), 64'(0));

        // Four back-to-back ties.
        tie_exp = RR_EN ? 4'b0101 : 4'b1111;
        for (int t = 0; t < 4; t++) begin
            run_txn(1'b1, 1'b1, $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, 2), 1'b1, $urandom_range(0, 2), $urandom, won);
            check("tie_grant", 64'(won), 64'(tie_exp[t]));
        end

        // LSU store with memory stalling for 3 cycles.
        run_txn(1'b0, 1'b1, 32'h0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF,
                3, 1'b1, 1, 32'h1234_5678, won);
        check("store_grant", 64'(won), 64'(1));

        // Timeouts for each owner, then response on the timeout cycle itself.
        run_txn(1'b1, 1'b0, 32'h8000_0040, 32'h0, 1'b0, 32'h0, 4'h0, 0, 1'b0, 0, 32'h0, won);
        run_txn(1'b0, 1'b1, 32'h0, 32'h8000_2004, 1'b0, 32'h0, 4'h3, 1, 1'b0, 0, 32'h0, won);
        run_txn(1'b0, 1'b1, 32'h0, 32'h8000_2008, 1'b0, 32'h0, 4'hC, 0, 1'b1, int'(TO),
                32'hCAFE_F00D, won);
        idle_cycles(1);

        // Reset pulsed during WAIT, followed by a late response.
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_3000;
        #1;
        check("rw_ifu_ready", 64'(ifu_req_ready), 64'(1));
        @(negedge clk);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        check("rw_mem_req_valid", 64'(mem_req_valid), 64'(1));
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        check("rw_wait_no_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rw_rst_no_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
        @(negedge clk);
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hBAD0_BAD0;
        #1;
        check("rw_late_resp_valid", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
        check("rw_late_resp_rdata", 64'(ifu_resp_rdata | lsu_resp_rdata), 64'(0));
        check("rw_mem_addr_cleared", 64'(mem_addr), 64'(0));
        check("rw_mem_req_valid", 64'(mem_req_valid), 64'(0));
        m_last = 1'b0;
        run_txn(1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 32'h0, 4'h0,
                0, 1'b1, 0, 32'h0000_0013, won);
        check("rw_next_ifu_grant", 64'(won), 64'(0));

        // Random traffic.
        for (int j = 0; j < 40; j++) begin
            r = $urandom_range(1, 3);
            run_txn(r[0], r[1], $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, 3), ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO) : $urandom_range(0, 3),
                    $urandom, won);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
